fpu_ss_wb_arbiter: RTL and testbench
====================================

Name: fpu_ss_wb_arbiter

Overview:
Writeback arbiter and sequencer for the FPU subsystem. Shares the single CV-X-IF result channel and the FP register-file write port between two producers: the FPU result port (tagged with fpu_tag_t) and the load path (tagged with mem_metadata_t). It uses round-robin arbitration into a one-entry output register. It also accumulates sticky FP exception flags.

Parameters:
ID_WIDTH, 4, instruction id width; must equal X_ID_WIDTH
FLEN, 32, FP register and result width
LD_FAULT_CODE, 6'd5, exccode reported on a load bus error

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
fpu_out_valid_i  in  1  FPU result valid
fpu_out_ready_o  out  1  FPU result accepted
fpu_result_i  in  FLEN  FPU result
fpu_status_i  in  5  fflags {NV,DZ,OF,UF,NX}
fpu_tag_i  in  fpu_tag_t  {addr, rd_is_fp, id}
mem_valid_i  in  1  load data valid
mem_ready_o  out  1  load data accepted
mem_rdata_i  in  FLEN  load data
mem_err_i  in  1  load bus error
mem_meta_i  in  mem_metadata_t  {id, rd, we}
fpr_we_o  out  1  FP regfile write enable
fpr_waddr_o  out  5  FP regfile address
fpr_wdata_o  out  FLEN  FP regfile data
x_result_valid_o  out  1  result valid to core
x_result_ready_i  in  1  core accepts result
x_result_o  out  x_result_t  result payload
fflags_o  out  5  sticky accumulated flags
fflags_clr_i  in  1  clear sticky flags
busy_o  out  1  output register occupied

Behaviour:
- Reset: all outputs 0, out_valid_q=0, fflags_q=0, rr_q=0 (FPU has priority first).
- Load enable: load_en = !out_valid_q || x_result_ready_i. When load_en=0, both ready outputs are 0. Ready is never asserted for a producer that was not granted.
- Grant:
  - Only one producer valid: that producer is granted.
  - Both valid: rr_q=0 grants FPU, rr_q=1 grants mem.
  - On each grant, rr_q <= (granted==FPU).
  - ready_o to the granted producer = load_en; handshake = valid && ready.
- Latency: handshake in cycle N -> x_result_valid_o and the fpr_we_o pulse in cycle N+1.
- Back-to-back: a new handshake is allowed in the same cycle the held result is accepted. This gives a sustained throughput of 1 result/cycle.
- FPU entry, rd_is_fp=1:
  - fpr_we=1, waddr=tag.addr, wdata=result.
  - x_result: we=0, data=0, rd=tag.addr, ecswe=3'b010, ecsdata[3:2]=2'b11 (FS dirty).
- FPU entry, rd_is_fp=0:
  - fpr_we=0.
  - x_result: we=1, data=result, rd=tag.addr, ecswe=0.
- FPU handshake: fflags_q |= fpu_status_i.
- Mem entry, err=0:
  - fpr_we=mem_meta.we, waddr=meta.rd, wdata=rdata.
  - x_result: we=0, ecswe=3'b010 if meta.we, else 0.
- Mem entry, err=1:
  - fpr_we=0.
  - x_result: exc=1, exccode=LD_FAULT_CODE, ecswe=0.
- x_result.id is taken from the tag or metadata. exc=0 and exccode=0 except on a load error.
- fpr_we_o is a single-cycle pulse in the first cycle of the entry only. A stalled x_result (ready=0) never rewrites the regfile.
- x_result_o is stable while valid && !ready.
- fflags_clr_i: clears fflags_q. Clear coincident with an FPU handshake -> fflags_q = fpu_status_i (new flags survive).
- busy_o = out_valid_q.
- Reset mid-operation: the held result is dropped with no further fpr write, and rr_q returns to 0.

Decomposition:
- Existing shared package fpu_ss_pkg already holds fpu_tag_t, mem_metadata_t, x_result_t and X_ID_WIDTH.
- Add to fpu_ss_pkg:
  - enum wb_src_e {WbFpu, WbMem}
  - constants FS_DIRTY_ECSWE=3'b010 and FS_DIRTY_ECSDATA=6'b001100
- One sub-module: fpu_ss_rr_arb2, a 2-input round-robin arbiter holding rr_q, with inputs req[1:0] and en, and output gnt[1:0].

Test Plan:
- FPU only, tag{addr=7, rd_is_fp=1, id=3}, result 0x3F800000, status 5'b00001 -> next cycle fpr_we=1, waddr=7, wdata=0x3F800000; x_result id=3, we=0, ecswe=010; fflags_o=00001.
- Both valid for 4 consecutive cycles, x_result_ready_i=1 -> grants FPU, mem, FPU, mem; one result per cycle; each fpr_we pulses exactly once per entry.
- x_result_ready_i=0 for 3 cycles holding an FPU int result (rd_is_fp=0, data 0x5) -> x_result_o stable at data=5, we=1; both ready outputs 0; fpr_we never asserted.
- Load with mem_err_i=1, meta{id=9, rd=4, we=1} -> exc=1, exccode=5, fpr_we=0.
- fflags_clr_i together with an FPU handshake carrying status 10000, after fflags_o=00011 -> fflags_o=10000.
- rst_ni low while out_valid_q=1 -> x_result_valid_o=0 immediately; no fpr_we after release; the first contended grant goes to FPU.

Source files
------------

// File: rtl/fpu_ss_pkg.sv
// rtl/fpu_ss_pkg.sv - shared FPU subsystem types and constants
package fpu_ss_pkg;

    localparam int X_ID_WIDTH = 4;
    localparam int X_RFW      = 32;

    typedef struct packed {
        logic [4:0]            addr;
        logic                  rd_is_fp;
        logic [X_ID_WIDTH-1:0] id;
    } fpu_tag_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rd;
        logic                  we;
    } mem_metadata_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [X_RFW-1:0]      data;
        logic [4:0]            rd;
        logic                  we;
        logic [2:0]            ecswe;
        logic [5:0]            ecsdata;
        logic                  exc;
        logic [5:0]            exccode;
    } x_result_t;

    typedef enum logic {
        WbFpu = 1'b0,
        WbMem = 1'b1
    } wb_src_e;

    // Writing mstatus.FS = dirty through the extension-context channel
    localparam logic [2:0] FS_DIRTY_ECSWE   = 3'b010;
    localparam logic [5:0] FS_DIRTY_ECSDATA = 6'b001100;

endpackage

// File: rtl/fpu_ss_rr_arb2.sv
// rtl/fpu_ss_rr_arb2.sv - two-requester round-robin arbiter
// req[0]/gnt[0] is the FPU, req[1]/gnt[1] the load path; rr_q=1 favours req[1].
module fpu_ss_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic rr_q;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Priority only moves on an actual transfer, so a stalled grant keeps its turn
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= 1'b0;
        end else if (en && (req != 2'b00)) begin
            rr_q <= gnt[0];
        end
    end

endmodule

// File: rtl/fpu_ss_wb_arbiter.sv
// rtl/fpu_ss_wb_arbiter.sv - writeback arbiter for FPU results and loads
// Both producers share one registered result slot feeding CV-X-IF and the FP regfile.
module fpu_ss_wb_arbiter
    import fpu_ss_pkg::*;
#(
    parameter int         ID_WIDTH      = 4,
    parameter int         FLEN          = 32,
    parameter logic [5:0] LD_FAULT_CODE = 6'd5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            fpu_out_valid_i,
    output logic            fpu_out_ready_o,
    input  logic [FLEN-1:0] fpu_result_i,
    input  logic [4:0]      fpu_status_i,
    input  fpu_tag_t        fpu_tag_i,
    input  logic            mem_valid_i,
    output logic            mem_ready_o,
    input  logic [FLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i,
    input  mem_metadata_t   mem_meta_i,
    output logic            fpr_we_o,
    output logic [4:0]      fpr_waddr_o,
    output logic [FLEN-1:0] fpr_wdata_o,
    output logic            x_result_valid_o,
    input  logic            x_result_ready_i,
    output x_result_t       x_result_o,
    output logic [4:0]      fflags_o,
    input  logic            fflags_clr_i,
    output logic            busy_o
);

    logic                out_valid_q;
    x_result_t           result_q;
    logic                fpr_we_q;
    logic [4:0]          fpr_waddr_q;
    logic [FLEN-1:0]     fpr_wdata_q;
    logic [4:0]          fflags_q;

    logic                load_en;
    logic [1:0]          gnt;
    wb_src_e             src;
    logic                fpu_hs;
    logic                mem_hs;
    logic                any_hs;

    x_result_t           result_d;
    logic                fpr_we_d;
    logic [4:0]          waddr_d;
    logic [FLEN-1:0]     wdata_d;
    logic [ID_WIDTH-1:0] sel_id;

    // The slot can take a new entry when empty or when its current entry leaves this cycle
    assign load_en = !out_valid_q || x_result_ready_i;

    fpu_ss_rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    ({mem_valid_i, fpu_out_valid_i}),
        .en     (load_en),
        .gnt    (gnt)
    );

    assign fpu_out_ready_o = gnt[0] & load_en;
    assign mem_ready_o     = gnt[1] & load_en;
    assign fpu_hs          = fpu_out_valid_i & fpu_out_ready_o;
    assign mem_hs          = mem_valid_i & mem_ready_o;
    assign any_hs          = fpu_hs | mem_hs;
    assign src             = gnt[1] ? WbMem : WbFpu;

    always_comb begin
        result_d = '0;
        fpr_we_d = 1'b0;
        waddr_d  = '0;
        wdata_d  = '0;
        sel_id   = '0;
        if (src == WbFpu) begin
            sel_id      = fpu_tag_i.id;
            result_d.rd = fpu_tag_i.addr;
            waddr_d     = fpu_tag_i.addr;
            wdata_d     = fpu_result_i;
            if (fpu_tag_i.rd_is_fp) begin
                fpr_we_d         = 1'b1;
                result_d.ecswe   = FS_DIRTY_ECSWE;
                result_d.ecsdata = FS_DIRTY_ECSDATA;
            end else begin
                result_d.we   = 1'b1;
                result_d.data = fpu_result_i;
            end
        end else begin
            sel_id      = mem_meta_i.id;
            result_d.rd = mem_meta_i.rd;
            waddr_d     = mem_meta_i.rd;
            wdata_d     = mem_rdata_i;
            if (mem_err_i) begin
                result_d.exc     = 1'b1;
                result_d.exccode = LD_FAULT_CODE;
            end else if (mem_meta_i.we) begin
                fpr_we_d         = 1'b1;
                result_d.ecswe   = FS_DIRTY_ECSWE;
                result_d.ecsdata = FS_DIRTY_ECSDATA;
            end
        end
        result_d.id = sel_id;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            fpr_we_q    <= 1'b0;
            fpr_waddr_q <= '0;
            fpr_wdata_q <= '0;
            fflags_q    <= '0;
        end else begin
            // Regfile write fires only on the load cycle; a stalled result never rewrites it
            fpr_we_q <= any_hs & fpr_we_d;
            if (any_hs) begin
                out_valid_q <= 1'b1;
                result_q    <= result_d;
                if (fpr_we_d) begin
                    fpr_waddr_q <= waddr_d;
                    fpr_wdata_q <= wdata_d;
                end
            end else if (x_result_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (fflags_clr_i) begin
                fflags_q <= fpu_hs ? fpu_status_i : 5'b00000;
            end else if (fpu_hs) begin
                fflags_q <= fflags_q | fpu_status_i;
            end
        end
    end

    assign fpr_we_o         = fpr_we_q;
    assign fpr_waddr_o      = fpr_waddr_q;
    assign fpr_wdata_o      = fpr_wdata_q;
    assign x_result_valid_o = out_valid_q;
    assign x_result_o       = result_q;
    assign fflags_o         = fflags_q;
    assign busy_o           = out_valid_q;

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// tb/tb_fpu_ss_wb_arbiter.sv - self-checking bench for fpu_ss_wb_arbiter
module tb_fpu_ss_wb_arbiter;
    import fpu_ss_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fpu_valid, fpu_ready;
    logic [31:0]   fpu_result;
    logic [4:0]    fpu_status;
    fpu_tag_t      fpu_tag;
    logic          mem_valid, mem_ready;
    logic [31:0]   mem_rdata;
    logic          mem_err;
    mem_metadata_t mem_meta;
    logic          fpr_we;
    logic [4:0]    fpr_waddr;
    logic [31:0]   fpr_wdata;
    logic          xv, xr;
    x_result_t     xres;
    logic [4:0]    fflags;
    logic          fclr;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    fpu_ss_wb_arbiter dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .fpu_out_valid_i  (fpu_valid),
        .fpu_out_ready_o  (fpu_ready),
        .fpu_result_i     (fpu_result),
        .fpu_status_i     (fpu_status),
        .fpu_tag_i        (fpu_tag),
        .mem_valid_i      (mem_valid),
        .mem_ready_o      (mem_ready),
        .mem_rdata_i      (mem_rdata),
        .mem_err_i        (mem_err),
        .mem_meta_i       (mem_meta),
        .fpr_we_o         (fpr_we),
        .fpr_waddr_o      (fpr_waddr),
        .fpr_wdata_o      (fpr_wdata),
        .x_result_valid_o (xv),
        .x_result_ready_i (xr),
        .x_result_o       (xres),
        .fflags_o         (fflags),
        .fflags_clr_i     (fclr),
        .busy_o           (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: one result slot, flags accumulator, and "who was served last"
    logic       m_valid, m_we, m_last_mem;
    x_result_t  m_res;
    logic [4:0] m_waddr;
    logic [31:0] m_wdata;
    logic [4:0] m_flags;

    function automatic int winner();
        if (fpu_valid && mem_valid) return m_last_mem ? 0 : 1;
        if (fpu_valid) return 0;
        if (mem_valid) return 1;
        return -1;
    endfunction

    function automatic logic can_take();
        return !m_valid || xr;
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        int   w;
        logic take;
        if (!rst_n) begin
            m_valid    = 1'b0;
            m_we       = 1'b0;
            m_last_mem = 1'b1;
            m_res      = '0;
            m_waddr    = '0;
            m_wdata    = '0;
            m_flags    = '0;
        end else begin
            w    = winner();
            take = (w >= 0) && can_take();
            if (fclr) m_flags = '0;
            if (take) begin
                m_res = '0;
                if (w == 0) begin
                    m_res.id   = fpu_tag.id;
                    m_res.rd   = fpu_tag.addr;
                    m_we       = fpu_tag.rd_is_fp;
                    if (fpu_tag.rd_is_fp) begin
                        m_res.ecswe   = 3'b010;
                        m_res.ecsdata = 6'b001100;
                        m_waddr       = fpu_tag.addr;
                        m_wdata       = fpu_result;
                    end else begin
                        m_res.we   = 1'b1;
                        m_res.data = fpu_result;
                    end
                    m_flags    = m_flags | fpu_status;
                    m_last_mem = 1'b0;
                end else begin
                    m_res.id = mem_meta.id;
                    m_res.rd = mem_meta.rd;
                    m_we     = mem_meta.we && !mem_err;
                    if (mem_err) begin
                        m_res.exc     = 1'b1;
                        m_res.exccode = 6'd5;
                    end else if (mem_meta.we) begin
                        m_res.ecswe   = 3'b010;
                        m_res.ecsdata = 6'b001100;
                        m_waddr       = mem_meta.rd;
                        m_wdata       = mem_rdata;
                    end
                    m_last_mem = 1'b1;
                end
                m_valid = 1'b1;
            end else begin
                m_we = 1'b0;
                if (xr) m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : cmp
        int w;
        if (chk_en) begin
            w = winner();
            chk("fpu_ready", 64'(fpu_ready), 64'(fpu_valid && w == 0 && can_take()));
            chk("mem_ready", 64'(mem_ready), 64'(mem_valid && w == 1 && can_take()));
            chk("x_valid", 64'(xv), 64'(m_valid));
            chk("busy", 64'(busy), 64'(m_valid));
            chk("fpr_we", 64'(fpr_we), 64'(m_we));
            chk("fflags", 64'(fflags), 64'(m_flags));
            if (m_valid) chk("x_result", 64'(xres), 64'(m_res));
            if (m_we) begin
                chk("fpr_waddr", 64'(fpr_waddr), 64'(m_waddr));
                chk("fpr_wdata", 64'(fpr_wdata), 64'(m_wdata));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fpu_valid = 1'b0;
        mem_valid = 1'b0;
        fclr      = 1'b0;
        mem_err   = 1'b0;
    endtask

    task automatic set_fpu(input logic [4:0] addr, input logic fp, input logic [3:0] id,
                           input logic [31:0] res, input logic [4:0] st);
        fpu_valid        = 1'b1;
        fpu_tag.addr     = addr;
        fpu_tag.rd_is_fp = fp;
        fpu_tag.id       = id;
        fpu_result       = res;
        fpu_status       = st;
    endtask

    task automatic set_mem(input logic [3:0] id, input logic [4:0] rd, input logic we,
                           input logic err, input logic [31:0] data);
        mem_valid   = 1'b1;
        mem_meta.id = id;
        mem_meta.rd = rd;
        mem_meta.we = we;
        mem_err     = err;
        mem_rdata   = data;
    endtask

    initial begin
        fpu_tag = '0; mem_meta = '0; fpu_result = '0; fpu_status = '0; mem_rdata = '0;
        idle();
        xr     = 1'b1;
        chk_en = 1'b1;
        cyc(); cyc();
        chk("rst_x_valid", 64'(xv), 64'd0);
        chk("rst_fpr_we", 64'(fpr_we), 64'd0);
        chk("rst_fflags", 64'(fflags), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_x_result", 64'(xres), 64'd0);
        rst_n = 1'b1;
        cyc();

        // FPU-only FP write
        set_fpu(5'd7, 1'b1, 4'd3, 32'h3F80_0000, 5'b00001);
        cyc();
        idle();
        chk("t1_fpr_we", 64'(fpr_we), 64'd1);
        chk("t1_waddr", 64'(fpr_waddr), 64'd7);
        chk("t1_wdata", 64'(fpr_wdata), 64'h3F80_0000);
        chk("t1_id", 64'(xres.id), 64'd3);
        chk("t1_we", 64'(xres.we), 64'd0);
        chk("t1_ecswe", 64'(xres.ecswe), 64'b010);
        chk("t1_ecsdata", 64'(xres.ecsdata[3:2]), 64'b11);
        chk("t1_fflags", 64'(fflags), 64'b00001);
        chk("t1_model_waddr", 64'(m_waddr), 64'd7);
        cyc();

        // mem-only transfer hands priority back to the FPU
        set_mem(4'd0, 5'd0, 1'b0, 1'b0, 32'h0);
        cyc();
        idle();
        cyc();

        // Contention: strict alternation at full rate
        set_fpu(5'd1, 1'b1, 4'd1, 32'h1111_1111, 5'b0);
        set_mem(4'd2, 5'd2, 1'b1, 1'b0, 32'h2222_2222);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t2_id", 64'(xres.id), (i % 2 == 0) ? 64'd1 : 64'd2);
            chk("t2_fpr_we", 64'(fpr_we), 64'd1);
            chk("t2_waddr", 64'(fpr_waddr), (i % 2 == 0) ? 64'd1 : 64'd2);
            chk("t2_valid", 64'(xv), 64'd1);
        end
        idle();
        cyc();

        // Stall holding an integer FPU result
        xr = 1'b0;
        set_fpu(5'd3, 1'b0, 4'd4, 32'h5, 5'b0);
        set_mem(4'd6, 5'd6, 1'b1, 1'b0, 32'h6);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("t3_data", 64'(xres.data), 64'd5);
            chk("t3_we", 64'(xres.we), 64'd1);
            chk("t3_fpu_ready", 64'(fpu_ready), 64'd0);
            chk("t3_mem_ready", 64'(mem_ready), 64'd0);
            chk("t3_fpr_we", 64'(fpr_we), 64'd0);
            cyc();
        end
        idle();
        xr = 1'b1;
        cyc();

        // Load bus error
        set_mem(4'd9, 5'd4, 1'b1, 1'b1, 32'hDEAD_BEEF);
        cyc();
        idle();
        chk("t4_exc", 64'(xres.exc), 64'd1);
        chk("t4_exccode", 64'(xres.exccode), 64'd5);
        chk("t4_fpr_we", 64'(fpr_we), 64'd0);
        chk("t4_id", 64'(xres.id), 64'd9);
        cyc();

        // Sticky flags and clear-with-handshake
        fclr = 1'b1;
        cyc();
        fclr = 1'b0;
        chk("t5_cleared", 64'(fflags), 64'd0);
        set_fpu(5'd8, 1'b1, 4'd5, 32'h0, 5'b00011);
        cyc();
        chk("t5_acc", 64'(fflags), 64'b00011);
        set_fpu(5'd8, 1'b1, 4'd5, 32'h0, 5'b10000);
        fclr = 1'b1;
        cyc();
        idle();
        chk("t5_clr_hs", 64'(fflags), 64'b10000);
        chk("t5_model_flags", 64'(m_flags), 64'b10000);
        cyc();

        // Reset while a result is held
        xr = 1'b0;
        set_fpu(5'd10, 1'b1, 4'd7, 32'hABCD, 5'b0);
        cyc();
        idle();
        chk("t6_held", 64'(xv), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_drop", 64'(xv), 64'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        xr    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("t6_no_we", 64'(fpr_we), 64'd0);
            chk("t6_no_valid", 64'(xv), 64'd0);
        end
        set_fpu(5'd1, 1'b1, 4'd1, 32'h1, 5'b0);
        set_mem(4'd2, 5'd2, 1'b1, 1'b0, 32'h2);
        cyc();
        idle();
        chk("t6_first_grant", 64'(xres.id), 64'd1);
        cyc();

        // Randomised traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            fpu_valid        = 1'($urandom_range(0, 1));
            fpu_tag.addr     = 5'($urandom);
            fpu_tag.rd_is_fp = 1'($urandom_range(0, 1));
            fpu_tag.id       = 4'($urandom);
            fpu_result       = $urandom;
            fpu_status       = 5'($urandom);
            mem_valid        = 1'($urandom_range(0, 1));
            mem_meta.id      = 4'($urandom);
            mem_meta.rd      = 5'($urandom);
            mem_meta.we      = 1'($urandom_range(0, 1));
            mem_err          = ($urandom_range(0, 7) == 0);
            mem_rdata        = $urandom;
            xr               = ($urandom_range(0, 3) != 0);
            fclr             = ($urandom_range(0, 15) == 0);
            cyc();
        end
        idle();
        xr = 1'b1;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
